// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between echo bytes from the byte FIFO and ASCII time reports.
// Messages are granted round-robin: one echo byte or one complete 10-byte report.
module uart_tx_sched #(
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        echo_valid,
    input  logic [7:0]  echo_data,
    output logic        echo_pop,
    input  logic        rpt_req,
    input  logic [23:0] rpt_time,
    output logic        rpt_busy,
    output logic        rpt_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);
    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic {SRC_ECHO, SRC_RPT} src_t;

    state_t        state, state_nxt;
    src_t          src, last_src;
    logic          rpt_pend;
    logic [23:0]   snap, work;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic          grant_echo, grant_rpt, advance, msg_end;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [7:0] rpt_byte(input logic [23:0] t, input logic [3:0] i);
        case (i)
            4'd0:    return digit_ascii(t[23:20]);
            4'd1:    return digit_ascii(t[19:16]);
            4'd3:    return digit_ascii(t[15:12]);
            4'd4:    return digit_ascii(t[11:8]);
            4'd6:    return digit_ascii(t[7:4]);
            4'd7:    return digit_ascii(t[3:0]);
            4'd2,
            4'd5:    return 8'h3A;
            4'd8:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state;
        echo_pop   = 1'b0;
        tx_start   = 1'b0;
        rpt_done   = 1'b0;
        grant_echo = 1'b0;
        grant_rpt  = 1'b0;
        advance    = 1'b0;
        msg_end    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the source that did not go last wins.
                if (echo_valid && (!rpt_pend || last_src == SRC_RPT)) begin
                    grant_echo = 1'b1;
                    echo_pop   = 1'b1;
                    state_nxt  = START;
                end else if (rpt_pend) begin
                    grant_rpt = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                // Hold off the start strobe while the transmitter still reports busy.
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy || cnt == CW'(BUSY_TIMEOUT - 1))
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (src == SRC_ECHO) begin
                        msg_end   = 1'b1;
                        state_nxt = IDLE;
                    end else if (idx == 4'd9) begin
                        msg_end   = 1'b1;
                        rpt_done  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = START;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rpt_busy = rpt_pend | (src == SRC_RPT && state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src      <= SRC_ECHO;
            last_src <= SRC_RPT;
            rpt_pend <= 1'b0;
            snap     <= '0;
            work     <= '0;
            idx      <= '0;
            cnt      <= '0;
            tx_data  <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT_BUSY) ? cnt + 1'b1 : '0;

            // A new request overrides the clear that comes with a report grant.
            if (rpt_req) begin
                snap     <= rpt_time;
                rpt_pend <= 1'b1;
            end else if (grant_rpt) begin
                rpt_pend <= 1'b0;
            end

            if (grant_echo) begin
                tx_data <= echo_data;
                src     <= SRC_ECHO;
            end else if (grant_rpt) begin
                work    <= snap;
                idx     <= 4'd0;
                tx_data <= rpt_byte(snap, 4'd0);
                src     <= SRC_RPT;
            end else if (advance) begin
                idx     <= idx + 4'd1;
                tx_data <= rpt_byte(work, idx + 4'd1);
            end

            if (msg_end)
                last_src <= src;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx busy model and echo FIFO.
module tb_uart_tx_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        echo_valid = 1'b0;
    logic [7:0]  echo_data = 8'h00;
    logic        echo_pop;
    logic        rpt_req = 1'b0;
    logic [23:0] rpt_time = 24'h0;
    logic        rpt_busy, rpt_done, tx_start, tx_busy;
    logic [7:0]  tx_data;
    logic        busy_model = 1'b0;
    logic        busy_force = 1'b0;

    int total = 0, bad = 0;
    int cyc = 0, busy_len = 3, left = 0, done_cnt = 0, viol = 0;
    logic [7:0] echo_q[$];
    logic [7:0] push_q[$];
    logic [7:0] tx_log[$];
    int start_cyc[$], pop_cyc[$];

    uart_tx_sched #(.BUSY_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .echo_valid(echo_valid), .echo_data(echo_data), .echo_pop(echo_pop),
        .rpt_req(rpt_req), .rpt_time(rpt_time), .rpt_busy(rpt_busy), .rpt_done(rpt_done),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;
    assign tx_busy = busy_model | busy_force;

    // Monitor: logs strobes sampled at the edge, and protocol violations.
    always @(posedge clk) begin
        if (tx_start) begin
            tx_log.push_back(tx_data);
            start_cyc.push_back(cyc);
        end
        if (echo_pop) pop_cyc.push_back(cyc);
        if (rpt_done) done_cnt++;
        if (tx_start && tx_busy) viol++;
        if (echo_pop && !echo_valid) viol++;
        cyc++;
    end

    // uart_tx model: busy rises the cycle after start, for busy_len cycles (0 = never).
    always @(posedge clk) begin
        if (tx_start && busy_len > 0) begin
            busy_model <= 1'b1;
            left       <= busy_len;
        end else if (left > 1) begin
            left <= left - 1;
        end else if (left == 1) begin
            left       <= 0;
            busy_model <= 1'b0;
        end
    end

    // Show-ahead FIFO model; tasks stage bytes in push_q.
    always @(posedge clk) begin
        if (echo_pop && echo_q.size() > 0) void'(echo_q.pop_front());
        #1;
        while (push_q.size() > 0) echo_q.push_back(push_q.pop_front());
        echo_valid = (echo_q.size() > 0);
        echo_data  = (echo_q.size() > 0) ? echo_q[0] : 8'h00;
    end

    task automatic wait_starts(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_req(input logic [23:0] t);
        @(negedge clk);
        rpt_time = t;
        rpt_req  = 1'b1;
        @(negedge clk);
        rpt_req  = 1'b0;
    endtask

    task automatic test_reset;
        rpt_req = 1'b1;
        repeat (2) @(negedge clk);
        total += 5;
        if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        if (echo_pop !== 1'b0) begin bad++; $display("FAIL reset_echo_pop got %b want 0", echo_pop); end
        if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        if (rpt_busy !== 1'b0) begin bad++; $display("FAIL reset_rpt_busy got %b want 0", rpt_busy); end
        if (rpt_done !== 1'b0) begin bad++; $display("FAIL reset_rpt_done got %b want 0", rpt_done); end
        rpt_req = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx_log.size() !== 0) begin bad++; $display("FAIL reset_no_start got %0d want 0", tx_log.size()); end
    endtask

    task automatic test_single_echo;
        bit ok;
        int b = tx_log.size(), p = pop_cyc.size();
        busy_len = 20;
        @(negedge clk);
        push_q.push_back(8'h41);
        push_q.push_back(8'h42);
        wait_starts(b + 2, 100, ok);
        total += 5;
        if (!ok) begin bad++; $display("FAIL echo_timeout got %0d starts want 2", tx_log.size() - b); end
        if (start_cyc[b] !== pop_cyc[p] + 1)
            begin bad++; $display("FAIL echo_latency got %0d want %0d", start_cyc[b], pop_cyc[p] + 1); end
        if (tx_log[b] !== 8'h41) begin bad++; $display("FAIL echo_byte0 got %h want 41", tx_log[b]); end
        if (pop_cyc[p+1] !== pop_cyc[p] + 23)
            begin bad++; $display("FAIL echo_next_grant got %0d want %0d", pop_cyc[p+1], pop_cyc[p] + 23); end
        if (tx_log[b+1] !== 8'h42) begin bad++; $display("FAIL echo_byte1 got %h want 42", tx_log[b+1]); end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_report;
        logic [7:0] exp [10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        int b = tx_log.size(), d = done_cnt, low = 0;
        bit hit = 1'b0;
        busy_len = 3;
        pulse_req(24'h12_34_56);
        for (int i = 0; i < 200; i++) begin
            if (rpt_done) begin hit = 1'b1; break; end
            if (!rpt_busy) low++;
            @(negedge clk);
        end
        total += 3;
        if (!hit) begin bad++; $display("FAIL rpt_done_seen got 0 want 1"); end
        if (low !== 0) begin bad++; $display("FAIL rpt_busy_held got %0d low cycles want 0", low); end
        if (tx_log.size() - b !== 10) begin bad++; $display("FAIL rpt_len got %0d want 10", tx_log.size() - b); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (tx_log[b+i] !== exp[i]) begin bad++; $display("FAIL rpt_byte%0d got %h want %h", i, tx_log[b+i], exp[i]); end
        end
        total++;
        if (start_cyc[b+1] - start_cyc[b] !== 5)
            begin bad++; $display("FAIL rpt_spacing got %0d want 5", start_cyc[b+1] - start_cyc[b]); end
        @(negedge clk);
        total += 2;
        if (rpt_busy !== 1'b0) begin bad++; $display("FAIL rpt_busy_after got %b want 0", rpt_busy); end
        if (done_cnt - d !== 1) begin bad++; $display("FAIL rpt_done_count got %0d want 1", done_cnt - d); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_contention;
        logic [7:0] exp [13] = '{8'h61, 8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33,
                                 8'h0D, 8'h0A, 8'h62, 8'h63};
        bit ok;
        int b = tx_log.size();
        busy_len = 3;
        @(negedge clk);
        push_q.push_back(8'h61);
        push_q.push_back(8'h62);
        push_q.push_back(8'h63);
        rpt_time = 24'h01_02_03;
        rpt_req  = 1'b1;
        @(negedge clk);
        rpt_req  = 1'b0;
        wait_starts(b + 13, 300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL cont_timeout got %0d starts want 13", tx_log.size() - b); end
        for (int i = 0; i < 13; i++) begin
            total++;
            if (tx_log[b+i] !== exp[i]) begin bad++; $display("FAIL cont_byte%0d got %h want %h", i, tx_log[b+i], exp[i]); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_requests_during;
        logic [7:0] exp [20] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A,
                                 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h32, 8'h0D, 8'h0A};
        bit ok;
        int b = tx_log.size(), d = done_cnt;
        busy_len = 3;
        pulse_req(24'h23_59_59);
        wait_starts(b + 3, 100, ok);
        rpt_time = 24'h00_00_01;
        rpt_req  = 1'b1;
        @(negedge clk);
        rpt_time = 24'h00_00_02;
        @(negedge clk);
        rpt_req  = 1'b0;
        wait_starts(b + 20, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL during_timeout got %0d starts want 20", tx_log.size() - b); end
        repeat (60) @(negedge clk);
        total += 2;
        if (tx_log.size() - b !== 20) begin bad++; $display("FAIL during_len got %0d want 20", tx_log.size() - b); end
        if (done_cnt - d !== 2) begin bad++; $display("FAIL during_done got %0d want 2", done_cnt - d); end
        for (int i = 0; i < 20; i++) begin
            total++;
            if (tx_log[b+i] !== exp[i]) begin bad++; $display("FAIL during_byte%0d got %h want %h", i, tx_log[b+i], exp[i]); end
        end
    endtask

    task automatic test_timeout_digits;
        logic [7:0] exp [10] = '{8'h3F, 8'h39, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A};
        bit ok;
        int b = tx_log.size(), d = done_cnt;
        busy_len = 0;
        pulse_req(24'hA9_00_00);
        wait_starts(b + 10, 200, ok);
        repeat (10) @(negedge clk);
        total += 3;
        if (!ok) begin bad++; $display("FAIL tmo_timeout got %0d starts want 10", tx_log.size() - b); end
        if (done_cnt - d !== 1) begin bad++; $display("FAIL tmo_done got %0d want 1", done_cnt - d); end
        if (start_cyc[b+1] - start_cyc[b] !== 6)
            begin bad++; $display("FAIL tmo_spacing got %0d want 6", start_cyc[b+1] - start_cyc[b]); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (tx_log[b+i] !== exp[i]) begin bad++; $display("FAIL tmo_byte%0d got %h want %h", i, tx_log[b+i], exp[i]); end
        end
        busy_len = 3;
    endtask

    task automatic test_busy_held;
        int b = tx_log.size();
        busy_force = 1'b1;
        @(negedge clk);
        push_q.push_back(8'h5A);
        @(negedge clk);
        total++;
        if (echo_pop !== 1'b1) begin bad++; $display("FAIL held_pop got %b want 1", echo_pop); end
        repeat (3) @(negedge clk);
        total++;
        if (tx_log.size() - b !== 0) begin bad++; $display("FAIL held_no_start got %0d want 0", tx_log.size() - b); end
        busy_force = 1'b0;
        #1;
        total += 2;
        if (tx_start !== 1'b1) begin bad++; $display("FAIL held_release_start got %b want 1", tx_start); end
        if (tx_data !== 8'h5A) begin bad++; $display("FAIL held_release_data got %h want 5a", tx_data); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int b = tx_log.size(), d = done_cnt, n;
        busy_len = 3;
        pulse_req(24'h12_34_56);
        wait_starts(b + 5, 100, ok);
        rpt_time = 24'h11_11_11;
        rpt_req  = 1'b1;
        @(negedge clk);
        rpt_req = 1'b0;
        rst     = 1'b1;
        #1;
        n = tx_log.size();
        total += 6;
        if (!ok) begin bad++; $display("FAIL rstmid_timeout got %0d starts want 5", tx_log.size() - b); end
        if (tx_start !== 1'b0) begin bad++; $display("FAIL rstmid_tx_start got %b want 0", tx_start); end
        if (echo_pop !== 1'b0) begin bad++; $display("FAIL rstmid_echo_pop got %b want 0", echo_pop); end
        if (tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_tx_data got %h want 00", tx_data); end
        if (rpt_busy !== 1'b0) begin bad++; $display("FAIL rstmid_rpt_busy got %b want 0", rpt_busy); end
        if (rpt_done !== 1'b0) begin bad++; $display("FAIL rstmid_rpt_done got %b want 0", rpt_done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        total += 2;
        if (tx_log.size() !== n) begin bad++; $display("FAIL rstmid_no_start got %0d want %0d", tx_log.size(), n); end
        if (done_cnt - d !== 0) begin bad++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d); end
    endtask

    task automatic test_invariants;
        total++;
        if (viol !== 0) begin bad++; $display("FAIL protocol_violations got %0d want 0", viol); end
    endtask

    initial begin
        test_reset;
        test_single_echo;
        test_report;
        test_contention;
        test_requests_during;
        test_timeout_digits;
        test_busy_held;
        test_reset_mid;
        test_invariants;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Time-shares the single uart_tx transmitter between two requesters.
- Echo path: bytes popped from the RX/TX byte FIFO.
- Report path: formats a BCD time snapshot from watch_stopwatch into the 10-byte ASCII message "HH:MM:SS\r\n".
- Sits between the FIFO output, the watch time digits and uart_tx; it is the only driver of uart_tx start_trigger and tx_data.

Parameters:
BUSY_TIMEOUT, 4, clk cycles to wait in WAIT_BUSY for tx_busy to rise before treating the byte as sent.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
echo_valid  in  1  echo byte available (FIFO not empty)
echo_data  in  8  echo byte; show-ahead, valid while echo_valid=1
echo_pop  out  1  one-cycle pop strobe to the FIFO
rpt_req  in  1  one-cycle request to send a time report
rpt_time  in  24  BCD digits {H1,H0,M1,M0,S1,S0}, 4 bits each, sampled on rpt_req
rpt_busy  out  1  report pending or in flight
rpt_done  out  1  one-cycle pulse after the last byte (LF) of a report completes
tx_start  out  1  one-cycle start pulse to uart_tx
tx_data  out  8  byte to uart_tx; stable from tx_start until the byte completes
tx_busy  in  1  uart_tx busy

Behaviour:
- Reset values: echo_pop=0, tx_start=0, tx_data=8'h00, rpt_busy=0, rpt_done=0. Internally: state=IDLE, rpt_pend=0, byte index=0, last_src=REPORT (so echo wins the first tie).
- Reset mid-operation aborts everything immediately. The pending report and snapshot are discarded. No rpt_done is issued.

Report capture:
- rpt_req=1 loads the snapshot register from rpt_time and sets rpt_pend=1.
- A rpt_req while a report is pending but not yet started overwrites the snapshot. Only one message is sent.
- A rpt_req while a report is in flight is queued as pending with the new snapshot. The in-flight message keeps its own copy, latched at message start.
- rpt_busy = rpt_pend OR (current source = REPORT and state != IDLE).

States: IDLE, START, WAIT_BUSY, WAIT_DONE.

IDLE:
- Arbitration is round-robin at message granularity: one echo byte, or one complete 10-byte report.
- If both requesters are pending, grant the one not equal to last_src.
- If only one is pending, grant it.
- Echo grant: echo_pop=1 in this cycle, echo_data latched into tx_data, src=ECHO, go to START.
- Report grant: copy the snapshot to the working register, clear rpt_pend (unless rpt_req is in the same cycle; rpt_req wins and sets it), idx=0, tx_data = byte 0, src=REPORT, go to START.

START:
- tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
- Latency: grant at cycle N gives tx_start at N+1.

WAIT_BUSY:
- Go to WAIT_DONE when tx_busy=1.
- Otherwise count. After BUSY_TIMEOUT cycles, treat the byte as done: take the WAIT_DONE exit with tx_busy=0 on the next cycle.

WAIT_DONE:
- Stay here while tx_busy=1.
- On tx_busy=0 with src=ECHO: last_src=ECHO, go to IDLE.
- On tx_busy=0 with src=REPORT and idx<9: idx+1, load the next byte into tx_data, go to START.
- On tx_busy=0 with src=REPORT and idx=9: rpt_done=1 for one cycle, last_src=REPORT, go to IDLE.

Report byte order:
- H1 H0 ':' M1 M0 ':' S1 S0 CR(8'h0D) LF(8'h0A).
- Digit to ASCII: 8'h30 + digit for digit <= 9.
- Digit 10..15 is sent as '?' (8'h3F).

Other rules:
- Echo bytes are never interleaved inside a report.
- echo_pop is only ever asserted in IDLE with echo_valid=1; it is never asserted with echo_valid=0.
- tx_start is never asserted while tx_busy=1 in the same cycle.
- A tx_busy that is already high in IDLE does not block arbitration, but START is not left until tx_busy=0.

Test Plan:
- Single echo: echo_valid=1, echo_data=8'h41, tx model with busy for 20 cycles starting 1 cycle after start -> echo_pop at N, tx_start at N+1 with tx_data=8'h41, next grant no earlier than busy falling.
- Report: rpt_req with rpt_time=24'h12_34_56 -> tx bytes 31 32 3A 33 34 3A 35 36 0D 0A; rpt_done pulses once after the LF; rpt_busy high from req+1 until rpt_done.
- Contention: echo FIFO holding 3 bytes 'a','b','c' plus rpt_req at the same cycle from IDLE -> order 'a', full report, 'b', 'c'; no echo byte inside the report.
- Requests during a report: second rpt_req (24'h00_00_01) at report byte 3, third rpt_req (24'h00_00_02) while the second is still pending -> exactly two reports, second = "00:00:02\r\n".
- Boundaries: rpt_time=24'hA9_00_00 -> first byte 8'h3F; tx_busy never rising -> each byte advances after BUSY_TIMEOUT=4 cycles, report still completes.
- rst asserted at report byte 5 -> all outputs 0 immediately, no rpt_done, no further tx_start until a new request.
